ir_fetch_ctrl: RTL

Fetch sequencer directly upstream of the 16-bit instruction register. On a fetch request it reads two consecutive bytes from an 8-bit memory at the program counter. It then drives the IR's half-load controls: clear, low byte at PC, high byte at PC+1. Finally it advances the PC by 2 and signals completion to the control unit.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_watchdog.sv | 31 +++
 rtl/ir_fetch_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding and the instruction register function-select codes.
package fetch_pkg;

   // Fetch sequencer states, in the order a fetch walks through them
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RD_LO = 3'd2,
      S_WR_LO = 3'd3,
      S_RD_HI = 3'd4,
      S_WR_HI = 3'd5,
      S_DONE  = 3'd6
   } fetch_state_t;

   // IR function select codes; the sequencer only ever issues clear and load
   localparam logic [1:0] FS_CLR  = 2'b00;
   localparam logic [1:0] FS_LOAD = 2'b01;
   localparam logic [1:0] FS_DEC  = 2'b10;
   localparam logic [1:0] FS_INC  = 2'b11;

   // True for the function selects the fetch sequencer is allowed to drive
   function automatic logic funsel_is_fetch_code(input logic [1:0] fs);
      return (fs == FS_CLR) || (fs == FS_LOAD);
   endfunction

   // True for the IR codes owned by the execute stage, never by fetch
   function automatic logic funsel_is_exec_code(input logic [1:0] fs);
      return (fs == FS_DEC) || (fs == FS_INC);
   endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Per-read wait counter for the fetch sequencer. The count is held at zero
// while no read is active, so it restarts on every entry to a read state,
// and it advances on each cycle the memory has not answered. The expiry
// flag rises in the cycle in which the count would reach TIMEOUT_CYCLES;
// a mem_valid in that same cycle suppresses expiry.
module fetch_watchdog #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic mem_valid,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   // Wait counter: cleared outside reads, counts cycles without mem_valid
   always_ff @(posedge clk) begin
      if (rst || !active) begin
         cnt <= '0;
      end else if (!mem_valid) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = active && !mem_valid && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ir_fetch_ctrl.sv
// Instruction fetch sequencer feeding a 16-bit IR through its half-load
// port: clear the IR, read/load the low byte at pc, read/load the high byte
// at pc+1, then advance pc by 2 and pulse fetch_done.
// Optional feature macro FETCH_TIMEOUT_EN: bounds each byte read to
// TIMEOUT_CYCLES wait cycles and reports an aborted fetch on fetch_err.
// Handshake: mem_rd/mem_addr form a request held stable until the memory
// returns mem_valid; mem_valid is ignored whenever mem_rd is low.
module ir_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int            AW             = 16,
   parameter logic [AW-1:0] RESET_PC       = '0,
   parameter int            TIMEOUT_CYCLES = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fetch_start,
   input  logic          pc_ld,
   input  logic [AW-1:0] pc_in,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          fetch_done,
   output logic          fetch_err,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_data,
   input  logic          mem_valid,
   output logic [7:0]    ir_i_half,
   output logic [1:0]    ir_funsel,
   output logic          ir_e,
   output logic          ir_l_h
);

   fetch_state_t state_q, state_d;
   logic [7:0]   byte_q;
   logic         in_read;
   logic         expired;

   assign in_read = (state_q == S_RD_LO) || (state_q == S_RD_HI);

`ifdef FETCH_TIMEOUT_EN
   logic err_q;

   fetch_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .active    (in_read),
      .mem_valid (mem_valid),
      .expired   (expired)
   );

   // Abort flag: set when a read expires, cleared when the next fetch begins
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
         err_q <= 1'b0;
      end else if (in_read && expired) begin
         err_q <= 1'b1;
      end
   end

   assign fetch_err = (state_q == S_DONE) && err_q;
`else
   // Without the watchdog a read never expires; the term only keeps the
   // parameter referenced and folds to zero.
   assign expired   = 1'b0 & (TIMEOUT_CYCLES < 0);
   assign fetch_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and output decode from the registered state
   always_comb begin
      state_d    = state_q;
      busy       = (state_q != S_IDLE);
      fetch_done = 1'b0;
      mem_rd     = 1'b0;
      mem_addr   = '0;
      ir_e       = 1'b0;
      ir_funsel  = FS_CLR;
      ir_l_h     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fetch_start) state_d = S_CLR;
         end
         S_CLR: begin
            ir_e    = 1'b1;
            state_d = S_RD_LO;
         end
         S_RD_LO: begin
            mem_rd   = 1'b1;
            mem_addr = pc;
            if (mem_valid)    state_d = S_WR_LO;
            else if (expired) state_d = S_DONE;
         end
         S_WR_LO: begin
            ir_e      = 1'b1;
            ir_funsel = FS_LOAD;
            state_d   = S_RD_HI;
         end
         S_RD_HI: begin
            mem_rd   = 1'b1;
            mem_addr = pc + AW'(1);
            if (mem_valid)    state_d = S_WR_HI;
            else if (expired) state_d = S_DONE;
         end
         S_WR_HI: begin
            ir_e      = 1'b1;
            ir_funsel = FS_LOAD;
            ir_l_h    = 1'b1;
            state_d   = S_DONE;
         end
         S_DONE: begin
            fetch_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Program counter: load only when idle and not starting, advance on success
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (state_q == S_IDLE) begin
         if (!fetch_start && pc_ld) pc <= pc_in;
      end else if ((state_q == S_DONE) && !fetch_err) begin
         pc <= pc + AW'(2);
      end
   end

   // Captured read byte; it stays on ir_i_half until the next capture
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_q <= '0;
      end else if (in_read && mem_valid) begin
         byte_q <= mem_data;
      end
   end

   assign ir_i_half = byte_q;

endmodule
